mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port memory: IDLE -> ACCESS (WAIT_CYC cycles) -> RESP.
// Define MEM_ARB_RR_EN for round-robin contention; default build gives data fixed priority.
module mem_arbiter #(
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_done,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        gnt_d, gnt_d_nxt;
    logic        lat_wr, lat_wr_nxt, lat_mis, lat_mis_nxt;
    logic [15:0] lat_addr, lat_addr_nxt, lat_wdata, lat_wdata_nxt;
    logic [15:0] f_rdata_q, f_rdata_nxt, d_rdata_q, d_rdata_nxt;
    logic        pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d, last_d_nxt;
    // Under contention, favour whichever requester was not served last.
    assign pick_d = d_req & (~f_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_d     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt_d     <= gnt_d_nxt;
            lat_wr    <= lat_wr_nxt;
            lat_mis   <= lat_mis_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            f_rdata_q <= f_rdata_nxt;
            d_rdata_q <= d_rdata_nxt;
`ifdef MEM_ARB_RR_EN
            last_d    <= last_d_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gnt_d_nxt     = gnt_d;
        lat_wr_nxt    = lat_wr;
        lat_mis_nxt   = lat_mis;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        f_rdata_nxt   = f_rdata_q;
        d_rdata_nxt   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d_nxt    = last_d;
`endif
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        f_done    = 1'b0;
        d_done    = 1'b0;
        d_err     = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (f_req || d_req) begin
                    gnt_d_nxt = pick_d;
                    cnt_nxt   = CNT_INIT;
`ifdef MEM_ARB_RR_EN
                    last_d_nxt = pick_d;
`endif
                    if (pick_d) begin
                        lat_addr_nxt  = d_addr;
                        lat_wr_nxt    = d_wr;
                        lat_wdata_nxt = d_wdata;
                        lat_mis_nxt   = d_addr[0];
                        // Misaligned data accesses never touch memory.
                        state_nxt     = d_addr[0] ? RESP : ACCESS;
                    end else begin
                        lat_addr_nxt  = f_addr & 16'hFFFE;
                        lat_wr_nxt    = 1'b0;
                        lat_wdata_nxt = '0;
                        lat_mis_nxt   = 1'b0;
                        state_nxt     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (cnt == 4'd0) begin
                    // Gated by rst so a reset landing here never commits the write.
                    mem_wr = lat_wr & rst;
                    if (!lat_wr) begin
                        if (gnt_d) d_rdata_nxt = mem_rdata;
                        else       f_rdata_nxt = mem_rdata;
                    end
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                f_done    = ~gnt_d & rst;
                d_done    = gnt_d & rst;
                d_err     = gnt_d & lat_mis & rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline reference model, per-cycle compare, directed
// literal checks, then randomized traffic with occasional resets.
module tb_mem_arbiter;
    localparam int W = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic        f_done, d_done, d_err, mem_wr, busy;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Environment memory: unwritten words read as a fixed address pattern.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h1224;
    endfunction

    logic [15:0] env_mem[256];
    bit          env_vld[256];
    assign mem_rdata = env_vld[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr);
    always @(posedge clk)
        if (mem_wr) begin
            env_mem[mem_addr[7:0]] <= mem_wdata;
            env_vld[mem_addr[7:0]] <= 1'b1;
        end

    // Reference model: one transaction record timed relative to its grant cycle.
    logic [15:0] sh_mem[256];
    bit          sh_vld[256];
    int          cyc = 0, t_grant = 0;
    bit          txn_v = 0, t_who = 0, t_wr = 0, t_mis = 0;
    logic [15:0] t_addr = '0, t_wdata = '0, e_frd = '0, e_drd = '0;
`ifdef MEM_ARB_RR_EN
    bit          last_d = 0;
`endif

    function automatic int done_k();
        return t_mis ? 1 : W + 1;
    endfunction

    always @(posedge clk) begin : model
        int  k;
        bit  take_d;
        logic [15:0] rd;
        k = cyc - t_grant;
        if (!rst) begin
            txn_v = 0; e_frd = '0; e_drd = '0;
`ifdef MEM_ARB_RR_EN
            last_d = 0;
`endif
        end else if (txn_v) begin
            if (!t_mis && k == W) begin
                rd = sh_vld[t_addr[7:0]] ? sh_mem[t_addr[7:0]] : init_val(t_addr);
                if (t_wr) begin
                    sh_mem[t_addr[7:0]] = t_wdata;
                    sh_vld[t_addr[7:0]] = 1'b1;
                end else if (t_who) e_drd = rd;
                else                e_frd = rd;
            end
            if (k == done_k()) txn_v = 0;
        end else if (f_req || d_req) begin
`ifdef MEM_ARB_RR_EN
            take_d = (f_req && d_req) ? !last_d : d_req;
            last_d = take_d;
`else
            take_d = d_req;
`endif
            txn_v = 1; t_grant = cyc; t_who = take_d;
            if (take_d) begin
                t_wr = d_wr; t_addr = d_addr; t_wdata = d_wdata; t_mis = d_addr[0];
            end else begin
                t_wr = 0; t_addr = f_addr & 16'hFFFE; t_wdata = '0; t_mis = 0;
            end
        end
        cyc = cyc + 1;
    end

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        int k;
        bit acc, rsp;
        k   = cyc - t_grant;
        acc = txn_v && !t_mis && k >= 1 && k <= W;
        rsp = txn_v && k == done_k();
        chkb("busy",      busy,      txn_v);
        chk ("mem_addr",  mem_addr,  acc ? t_addr : 16'h0);
        chk ("mem_wdata", mem_wdata, acc ? t_wdata : 16'h0);
        chkb("mem_wr",    mem_wr,    acc && k == W && t_wr && rst);
        chkb("f_done",    f_done,    rsp && !t_who && rst);
        chkb("d_done",    d_done,    rsp && t_who && rst);
        chkb("d_err",     d_err,     rsp && t_mis && rst);
        chk ("f_rdata",   f_rdata,   e_frd);
        chk ("d_rdata",   d_rdata,   e_drd);
    end

    // Directed observation helper: records what happens in the n cycles after a request.
    int          o_done, o_wr_n, o_wr_at;
    logic        o_err;
    logic [15:0] o_wa, o_wd, o_ma1, o_frd;

    task automatic run_obs(input int n);
        o_done = 0; o_wr_n = 0; o_wr_at = 0; o_err = 0;
        o_wa = '0; o_wd = '0; o_ma1 = '0; o_frd = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (i == 1) o_ma1 = mem_addr;
            if (mem_wr) begin
                o_wr_n++; o_wr_at = i; o_wa = mem_addr; o_wd = mem_wdata;
            end
            if ((f_done || d_done) && o_done == 0) begin
                o_done = i; o_err = d_err; o_frd = f_rdata;
                f_req = 0; d_req = 0;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        chkb("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        int  n, kk;
        logic [3:0] seq;
        bit  fp, dp, fdn, ddn;

        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_busy", busy, 1'b0);
        chk ("rst_d_rdata", d_rdata, 16'h0);
        rst = 1;

        // Continuous contention for four grants.
        f_req = 1; f_addr = 16'h0040; d_req = 1; d_wr = 0; d_addr = 16'h0042;
        n = 0; seq = '0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(posedge clk); #1;
            if (f_done) begin seq = {seq[2:0], 1'b0}; n++; end
            if (d_done) begin seq = {seq[2:0], 1'b1}; n++; end
            if (n == 4) begin f_req = 0; d_req = 0; end
        end
        f_req = 0; d_req = 0;
        chk("arb_grants", 16'(n), 16'd4);
`ifdef MEM_ARB_RR_EN
        chk("arb_order", {12'h0, seq}, 16'h000A);
`else
        chk("arb_order", {12'h0, seq}, 16'h000F);
`endif
        wait_idle();

        // Odd fetch address is aligned down; memory holds 0x1234 at 0x0010.
        @(posedge clk); #1;
        f_req = 1; f_addr = 16'h0011;
        run_obs(5);
        chk("fetch_addr", o_ma1, 16'h0010);
        chk("fetch_done_at", 16'(o_done), 16'd3);
        chk("fetch_rdata", o_frd, 16'h1234);
        chk("fetch_no_wr", 16'(o_wr_n), 16'd0);

        // Aligned write.
        @(posedge clk); #1;
        d_req = 1; d_wr = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        run_obs(5);
        chk("wr_count", 16'(o_wr_n), 16'd1);
        chk("wr_at", 16'(o_wr_at), 16'd2);
        chk("wr_addr", o_wa, 16'h0010);
        chk("wr_data", o_wd, 16'hBEEF);
        chk("wr_done_at", 16'(o_done), 16'd3);

        // Misaligned write completes with error after one cycle.
        @(posedge clk); #1;
        d_req = 1; d_wr = 1; d_addr = 16'h0003; d_wdata = 16'h5555;
        run_obs(4);
        chk("mis_done_at", 16'(o_done), 16'd1);
        chkb("mis_err", o_err, 1'b1);
        chk("mis_no_wr", 16'(o_wr_n), 16'd0);

        // Reset in the second access cycle of a write.
        @(posedge clk); #1;
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'hCAFE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chkb("rstacc_wr", mem_wr, 1'b0);
        chkb("rstacc_done", d_done, 1'b0);
        @(posedge clk); #1;
        chkb("rstacc_busy", busy, 1'b0);
        chkb("rstacc_done2", d_done, 1'b0);
        chk ("rstacc_addr", mem_addr, 16'h0);
        chk ("rstacc_frd", f_rdata, 16'h0);
        chk ("rstacc_drd", d_rdata, 16'h0);
        chkb("rstacc_mem", env_vld[32], 1'b0);
        d_req = 0; d_wr = 0; rst = 1;

        // Randomized traffic, requests held until their modelled completion.
        fp = 0; dp = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            kk  = cyc - t_grant;
            fdn = txn_v && !t_who && kk == done_k();
            ddn = txn_v && t_who && kk == done_k();
            rst = ($urandom_range(0, 299) != 0);
            if (fdn || !rst) fp = 0;
            if (ddn || !rst) dp = 0;
            if (!fp && rst && $urandom_range(0, 2) == 0) begin
                fp = 1; f_addr = 16'($urandom_range(0, 255));
            end
            if (!dp && rst && $urandom_range(0, 2) == 0) begin
                dp = 1;
                d_wr = 1'($urandom_range(0, 1));
                d_addr = {8'h0, 7'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0)};
                d_wdata = 16'($urandom);
            end
            // Once granted, a requester may drop req early without aborting.
            f_req = fp && !(txn_v && !t_who && $urandom_range(0, 3) == 0);
            d_req = dp && !(txn_v && t_who && $urandom_range(0, 3) == 0);
        end
        rst = 1; f_req = 0; d_req = 0;
        repeat (6) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
